// File: rtl/universal_shift_register.sv
// universal_shift_register: parametrised shift/rotate/load register with a self-timed burst shifter
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   en              clock enable, freezes all state (done is cleared)
//   mode            single-cycle operation select when idle
//   si_right        serial in to bit 0 on shifts toward MSB
//   si_left         serial in to bit WIDTH-1 on shifts toward LSB
//   load_data       parallel load value
//   burst_start     start a burst of burst_len shifts in direction burst_dir
//   burst_len       number of positions, clamped to WIDTH
//   burst_dir       0 = toward MSB, 1 = toward LSB
//   out             register contents; so_msb/so_lsb are its end bits
//   busy            burst in progress with shifts remaining
//   done            one-cycle pulse after the last burst shift
module universal_shift_register #(
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int LW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             si_right,
   input  logic             si_left,
   input  logic [WIDTH-1:0] load_data,
   input  logic             burst_start,
   input  logic [LW-1:0]    burst_len,
   input  logic             burst_dir,
   output logic [WIDTH-1:0] out,
   output logic             so_msb,
   output logic             so_lsb,
   output logic             busy,
   output logic             done
);
   typedef enum logic {IDLE, BURST} state_t;
   localparam logic [LW-1:0] W_L = LW'(WIDTH);
   state_t state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d, shl, shr;
   logic [LW-1:0] cnt_q, cnt_d, l_eff;
   logic dir_q, dir_d, done_q, done_d;
   assign l_eff = (burst_len > W_L) ? W_L : burst_len;
   assign shl = {q_q[WIDTH-2:0], si_right};
   assign shr = {si_left, q_q[WIDTH-1:1]};
   always_comb begin
      q_d = q_q;
      state_d = state_q;
      dir_d = dir_q;
      cnt_d = cnt_q;
      done_d = 1'b0;
      if (en) begin
         if (state_q == BURST) begin
            q_d = dir_q ? shr : shl;
            cnt_d = cnt_q - 1'b1;
            state_d = (cnt_q == LW'(1)) ? IDLE : BURST;
            done_d = (cnt_q == LW'(1));
         end else if (burst_start && l_eff != '0) begin
            // first shift happens on the start edge itself
            q_d = burst_dir ? shr : shl;
            dir_d = burst_dir;
            cnt_d = l_eff - 1'b1;
            state_d = (l_eff == LW'(1)) ? IDLE : BURST;
            done_d = (l_eff == LW'(1));
         end else begin
            case (mode)
               3'b001: q_d = shl;
               3'b010: q_d = shr;
               3'b011: q_d = load_data;
               3'b100: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
               3'b101: q_d = {q_q[0], q_q[WIDTH-1:1]};
               3'b110: q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
               default: q_d = q_q;
            endcase
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= RESET_VAL;
         state_q <= IDLE;
         dir_q <= 1'b0;
         cnt_q <= '0;
         done_q <= 1'b0;
      end else begin
         q_q <= q_d;
         state_q <= state_d;
         dir_q <= dir_d;
         cnt_q <= cnt_d;
         done_q <= done_d;
      end
   end
   assign out = q_q;
   assign so_msb = q_q[WIDTH-1];
   assign so_lsb = q_q[0];
   assign busy = (state_q == BURST);
   assign done = done_q;
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed checks of modes, bursts, stalls, boundaries and reset
module tb_universal_shift_register;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic [2:0] mode = '0;
   logic si_right = 1'b0;
   logic si_left = 1'b0;
   logic [7:0] load_data = '0;
   logic burst_start = 1'b0;
   logic [3:0] burst_len = '0;
   logic burst_dir = 1'b0;
   logic [7:0] out;
   logic so_msb, so_lsb, busy, done;
   int total = 0;
   int bad = 0;

   universal_shift_register #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .si_right(si_right),
      .si_left(si_left), .load_data(load_data), .burst_start(burst_start),
      .burst_len(burst_len), .burst_dir(burst_dir), .out(out), .so_msb(so_msb),
      .so_lsb(so_lsb), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic en;
      logic [2:0] mode;
      logic bs;
      logic [3:0] len;
      logic dir, sir, sil;
      logic [7:0] ld, eo;
      logic eb, ed;
   } vec_t;

   function automatic vec_t mk(logic e, logic [2:0] m, logic bs, logic [3:0] len, logic dir,
                               logic sir, logic sil, logic [7:0] ld, logic [7:0] eo,
                               logic eb, logic ed);
      vec_t v;
      v.en = e; v.mode = m; v.bs = bs; v.len = len; v.dir = dir;
      v.sir = sir; v.sil = sil; v.ld = ld; v.eo = eo; v.eb = eb; v.ed = ed;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v);
      en = v.en; mode = v.mode; burst_start = v.bs; burst_len = v.len;
      burst_dir = v.dir; si_right = v.sir; si_left = v.sil; load_data = v.ld;
      step();
   endtask

   task automatic test_reset();
      step();
      step();
      total++;
      if (out !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_init out=%h busy=%b done=%b exp A5/0/0", out, busy, done);
      end
      rst_n = 1'b1;
      apply(mk(1, 3'b011, 0, 0, 0, 0, 0, 8'h3C, 8'h3C, 0, 0));
      total++;
      if (out !== 8'h3C) begin bad++; $display("FAIL load_3c out=%h exp 3c", out); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_async out=%h busy=%b done=%b exp A5/0/0", out, busy, done);
      end
      #1 rst_n = 1'b1;
      apply(mk(1, 3'b011, 0, 0, 0, 0, 0, 8'h3C, 8'h3C, 0, 0));
      total++;
      if (out !== 8'h3C) begin bad++; $display("FAIL reload_3c out=%h exp 3c", out); end
   endtask

   task automatic test_modes();
      vec_t v[11];
      v[0]  = mk(1, 3'b011, 0, 0, 0, 0, 0, 8'h81, 8'h81, 0, 0);
      v[1]  = mk(1, 3'b001, 0, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0);
      v[2]  = mk(1, 3'b100, 0, 0, 0, 0, 0, 8'h00, 8'h04, 0, 0);
      v[3]  = mk(1, 3'b011, 0, 0, 0, 0, 0, 8'h81, 8'h81, 0, 0);
      v[4]  = mk(1, 3'b101, 0, 0, 0, 0, 0, 8'h00, 8'hC0, 0, 0);
      v[5]  = mk(1, 3'b011, 0, 0, 0, 0, 0, 8'h81, 8'h81, 0, 0);
      v[6]  = mk(1, 3'b110, 0, 0, 0, 0, 0, 8'h00, 8'hC0, 0, 0);
      v[7]  = mk(1, 3'b010, 0, 0, 0, 0, 0, 8'h00, 8'h60, 0, 0);
      v[8]  = mk(1, 3'b001, 0, 0, 0, 1, 0, 8'h00, 8'hC1, 0, 0);
      v[9]  = mk(1, 3'b111, 0, 0, 0, 1, 1, 8'hFF, 8'hC1, 0, 0);
      v[10] = mk(0, 3'b011, 0, 0, 0, 1, 1, 8'hFF, 8'hC1, 0, 0);
      for (int i = 0; i < 11; i++) begin
         apply(v[i]);
         total++;
         if (out !== v[i].eo || so_msb !== v[i].eo[7] || so_lsb !== v[i].eo[0]) begin
            bad++;
            $display("FAIL mode_%0d out=%h msb=%b lsb=%b exp %h", i, out, so_msb, so_lsb, v[i].eo);
         end
      end
   endtask

   task automatic test_burst_lsb();
      vec_t v[7];
      v[0] = mk(1, 3'b011, 0, 0, 0, 0, 0, 8'hF0, 8'hF0, 0, 0);
      v[1] = mk(1, 3'b000, 1, 4, 1, 0, 0, 8'h00, 8'h78, 1, 0);
      v[2] = mk(1, 3'b000, 0, 0, 0, 1, 0, 8'h00, 8'h3C, 1, 0);
      v[3] = mk(1, 3'b000, 0, 0, 0, 1, 0, 8'h00, 8'h1E, 1, 0);
      v[4] = mk(1, 3'b000, 0, 0, 0, 1, 0, 8'h00, 8'h0F, 0, 1);
      v[5] = mk(1, 3'b000, 0, 0, 0, 1, 0, 8'h00, 8'h0F, 0, 0);
      v[6] = mk(1, 3'b000, 0, 0, 0, 1, 0, 8'h00, 8'h0F, 0, 0);
      for (int i = 0; i < 7; i++) begin
         apply(v[i]);
         total++;
         if (out !== v[i].eo || busy !== v[i].eb || done !== v[i].ed) begin
            bad++;
            $display("FAIL burst_lsb_%0d out=%h busy=%b done=%b exp %h/%b/%b",
                     i, out, busy, done, v[i].eo, v[i].eb, v[i].ed);
         end
      end
   endtask

   task automatic test_burst_stall();
      vec_t v[7];
      v[0] = mk(1, 3'b011, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      v[1] = mk(1, 3'b000, 1, 3, 0, 1, 0, 8'h00, 8'h01, 1, 0);
      v[2] = mk(0, 3'b011, 1, 3, 1, 1, 0, 8'hFF, 8'h01, 1, 0);
      v[3] = mk(0, 3'b011, 1, 3, 1, 1, 0, 8'hFF, 8'h01, 1, 0);
      v[4] = mk(1, 3'b011, 1, 3, 1, 1, 0, 8'hFF, 8'h03, 1, 0);
      v[5] = mk(1, 3'b011, 1, 3, 1, 1, 0, 8'hFF, 8'h07, 0, 1);
      v[6] = mk(1, 3'b000, 0, 0, 0, 1, 0, 8'h00, 8'h07, 0, 0);
      for (int i = 0; i < 7; i++) begin
         apply(v[i]);
         total++;
         if (out !== v[i].eo || busy !== v[i].eb || done !== v[i].ed) begin
            bad++;
            $display("FAIL burst_stall_%0d out=%h busy=%b done=%b exp %h/%b/%b",
                     i, out, busy, done, v[i].eo, v[i].eb, v[i].ed);
         end
      end
   endtask

   task automatic test_boundary();
      vec_t v[16];
      logic [7:0] e;
      v[0] = mk(1, 3'b011, 0, 0, 0, 0, 0, 8'h81, 8'h81, 0, 0);
      v[1] = mk(1, 3'b001, 1, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0);
      v[2] = mk(1, 3'b000, 0, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0);
      v[3] = mk(1, 3'b000, 1, 1, 1, 0, 1, 8'h00, 8'h81, 0, 1);
      v[4] = mk(0, 3'b011, 0, 0, 0, 0, 0, 8'hFF, 8'h81, 0, 0);
      v[5] = mk(1, 3'b011, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      v[6] = mk(1, 3'b000, 1, 15, 0, 1, 0, 8'h00, 8'h01, 1, 0);
      e = 8'h01;
      for (int i = 7; i < 13; i++) begin
         e = {e[6:0], 1'b1};
         v[i] = mk(1, 3'b000, 0, 0, 0, 1, 0, 8'h00, e, 1, 0);
      end
      v[13] = mk(1, 3'b000, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0, 1);
      v[14] = mk(1, 3'b000, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0, 0);
      v[15] = mk(1, 3'b001, 0, 0, 0, 0, 0, 8'h00, 8'hFE, 0, 0);
      for (int i = 0; i < 16; i++) begin
         apply(v[i]);
         total++;
         if (out !== v[i].eo || busy !== v[i].eb || done !== v[i].ed) begin
            bad++;
            $display("FAIL boundary_%0d out=%h busy=%b done=%b exp %h/%b/%b",
                     i, out, busy, done, v[i].eo, v[i].eb, v[i].ed);
         end
      end
   endtask

   task automatic test_back_to_back();
      vec_t v[6];
      v[0] = mk(1, 3'b011, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      v[1] = mk(1, 3'b000, 1, 2, 0, 1, 0, 8'h00, 8'h01, 1, 0);
      v[2] = mk(1, 3'b000, 1, 2, 1, 1, 0, 8'h00, 8'h03, 0, 1);
      v[3] = mk(1, 3'b000, 1, 2, 1, 1, 0, 8'h00, 8'h01, 1, 0);
      v[4] = mk(1, 3'b000, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1);
      v[5] = mk(1, 3'b000, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0);
      for (int i = 0; i < 6; i++) begin
         apply(v[i]);
         total++;
         if (out !== v[i].eo || busy !== v[i].eb || done !== v[i].ed) begin
            bad++;
            $display("FAIL b2b_%0d out=%h busy=%b done=%b exp %h/%b/%b",
                     i, out, busy, done, v[i].eo, v[i].eb, v[i].ed);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      vec_t v[3];
      apply(mk(1, 3'b011, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
      apply(mk(1, 3'b000, 1, 5, 0, 1, 0, 8'h00, 8'h01, 1, 0));
      burst_start = 1'b0;
      step();
      total++;
      if (out !== 8'h03 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rmb_pre out=%h busy=%b exp 03/1", out, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out !== 8'hA5 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL rmb_reset out=%h busy=%b done=%b exp A5/0/0", out, busy, done);
      end
      #1 rst_n = 1'b1;
      v[0] = mk(1, 3'b000, 0, 0, 0, 1, 0, 8'h00, 8'hA5, 0, 0);
      v[1] = mk(1, 3'b000, 1, 2, 1, 0, 1, 8'h00, 8'hD2, 1, 0);
      v[2] = mk(1, 3'b000, 0, 0, 0, 0, 1, 8'h00, 8'hE9, 0, 1);
      for (int i = 0; i < 3; i++) begin
         apply(v[i]);
         total++;
         if (out !== v[i].eo || busy !== v[i].eb || done !== v[i].ed) begin
            bad++;
            $display("FAIL rmb_%0d out=%h busy=%b done=%b exp %h/%b/%b",
                     i, out, busy, done, v[i].eo, v[i].eb, v[i].ed);
         end
      end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_burst_lsb();
      test_burst_stall();
      test_boundary();
      test_back_to_back();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
